// File: rtl/instruction_fetcher.sv
// instruction_fetcher: boots registers 1..7 from ROM, then streams instructions with jump squash and stall skid.
module instruction_fetcher #(
   parameter int WIDTH = 16,
   parameter int ADDR_WIDTH = 8,
   parameter int REGS_CODING = 3,
   parameter int BOOT_LEN = 8,
   parameter logic [WIDTH-1:0] NOP_WORD = 16'h02C2
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   start,
   input  logic                   stall,
   input  logic                   jumpValid,
   input  logic [ADDR_WIDTH-1:0]  jumpTarget,
   output logic [ADDR_WIDTH-1:0]  romAddr,
   input  logic [WIDTH-1:0]       romData,
   output logic [WIDTH-1:0]       instrOut,
   output logic                   instrValid,
   output logic [REGS_CODING-1:0] regChoose,
   output logic [WIDTH-1:0]       regData,
   output logic                   busy
);
   typedef enum logic [1:0] {IDLE, BOOT, FETCH} state_t;
   localparam logic [ADDR_WIDTH-1:0] LAST_BOOT = ADDR_WIDTH'((1 << REGS_CODING) - 1);
   localparam logic [ADDR_WIDTH-1:0] FIRST = ADDR_WIDTH'(BOOT_LEN);
   state_t state, state_n;
   logic [ADDR_WIDTH-1:0] addr_n;
   logic a_vld, a_vld_n, a_boot, a_boot_n;
   logic b_vld, b_boot;
   logic [REGS_CODING-1:0] b_idx;
   logic [WIDTH-1:0] skid, src_data;
   logic skid_full, skid_vld, src_vld;
   logic jump, hold;
   assign busy = state != IDLE;
   // a_* tags the address on romAddr, b_* tags the word now on romData
   always_comb begin
      state_n = state;
      addr_n = romAddr;
      a_vld_n = a_vld;
      a_boot_n = a_boot;
      jump = state == FETCH && !b_boot && jumpValid;
      hold = state == FETCH && !b_boot && stall && !jumpValid;
      src_data = skid_full ? skid : romData;
      src_vld = skid_full ? skid_vld : b_vld;
      case (state)
         IDLE: if (start) begin
            state_n = BOOT;
            addr_n = ADDR_WIDTH'(1);
            a_boot_n = 1'b1;
         end
         BOOT: if (romAddr == LAST_BOOT) begin
            state_n = FETCH;
            addr_n = FIRST;
            a_boot_n = 1'b0;
            a_vld_n = 1'b1;
         end else addr_n = romAddr + 1'b1;
         default: addr_n = jump ? jumpTarget : hold ? romAddr : (&romAddr) ? FIRST : romAddr + 1'b1;
      endcase
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
         romAddr <= '0;
         a_vld <= 1'b0;
         a_boot <= 1'b0;
         b_vld <= 1'b0;
         b_boot <= 1'b0;
         b_idx <= '0;
         skid <= '0;
         skid_full <= 1'b0;
         skid_vld <= 1'b0;
         instrOut <= NOP_WORD;
         instrValid <= 1'b0;
         regChoose <= '0;
         regData <= '0;
      end else begin
         state <= state_n;
         romAddr <= addr_n;
         a_vld <= a_vld_n;
         a_boot <= a_boot_n;
         b_vld <= a_vld && !jump;
         b_boot <= a_boot;
         b_idx <= romAddr[REGS_CODING-1:0];
         if (hold) begin
            // the word landing on the first stall cycle would be lost, so park it
            if (!skid_full) begin
               skid <= romData;
               skid_vld <= b_vld;
               skid_full <= 1'b1;
            end
            regChoose <= '0;
         end else begin
            skid_full <= 1'b0;
            instrOut <= (src_vld && !jump) ? src_data : NOP_WORD;
            instrValid <= src_vld && !jump;
            regChoose <= b_boot ? b_idx : '0;
            if (b_boot) regData <= romData;
         end
      end
   end
endmodule

// File: tb/tb_instruction_fetcher.sv
// tb_instruction_fetcher: random and directed checks of boot, fetch, jump, stall and reset against a stream model.
module tb_instruction_fetcher;
   localparam int W = 16, AW = 8, RC = 3, BL = 8;
   localparam logic [W-1:0] NOP = 16'h02C2;
   logic clock = 0, reset = 1, start = 0, stall = 0, jumpValid = 0;
   logic [AW-1:0] jumpTarget = 0, romAddr;
   logic [W-1:0] romData = 0, instrOut, regData;
   logic instrValid, busy;
   logic [RC-1:0] regChoose;
   logic [W-1:0] rom [256];
   int n_checks = 0, n_fail = 0;
   bit on = 0;
   int d = 0, nops = 0;
   logic [W-1:0] exp_out = NOP;
   logic exp_vld = 0;

   instruction_fetcher #(.WIDTH(W), .ADDR_WIDTH(AW), .REGS_CODING(RC), .BOOT_LEN(BL), .NOP_WORD(NOP)) dut (
      .clock(clock), .reset(reset), .start(start), .stall(stall), .jumpValid(jumpValid),
      .jumpTarget(jumpTarget), .romAddr(romAddr), .romData(romData), .instrOut(instrOut),
      .instrValid(instrValid), .regChoose(regChoose), .regData(regData), .busy(busy));

   always #5 clock = ~clock;
   always @(posedge clock) romData <= rom[romAddr];

   function automatic int nxt(int a);
      return a == 255 ? BL : a + 1;
   endfunction

   // Stream model: output walks the address sequence; a jump yields two NOPs then the target; a stall just holds.
   task automatic tick(input logic s, input logic j, input logic [AW-1:0] t);
      stall = s; jumpValid = j; jumpTarget = t;
      @(posedge clock);
      if (on) begin
         if (j) begin exp_out = NOP; exp_vld = 0; nops = 1; d = int'(t); end
         else if (!s) begin
            if (nops > 0) begin exp_out = NOP; exp_vld = 0; nops--; end
            else begin exp_out = rom[d]; exp_vld = 1; d = nxt(d); end
         end
      end
      #1;
   endtask

   task automatic fill_structured();
      for (int a = 0; a < 256; a++) rom[a] = W'(a);
      for (int k = 1; k < 8; k++) rom[k] = W'(16'h1111 * k);
   endtask

   task automatic test_reset();
      on = 0; reset = 1;
      tick(0, 0, 0); tick(0, 0, 0);
      n_checks++; if (romAddr !== 0 || busy !== 0 || instrValid !== 0) begin n_fail++; $display("FAIL reset ctrl: romAddr=%h busy=%b vld=%b want 0 0 0", romAddr, busy, instrValid); end
      n_checks++; if (instrOut !== NOP || regChoose !== 0 || regData !== 0) begin n_fail++; $display("FAIL reset data: instr=%h rc=%0d rd=%h want %h 0 0", instrOut, regChoose, regData, NOP); end
      reset = 0;
      tick(0, 0, 0); tick(1, 1, 8'h33);
      n_checks++; if (romAddr !== 0 || busy !== 0 || instrOut !== NOP) begin n_fail++; $display("FAIL idle hold: romAddr=%h busy=%b instr=%h", romAddr, busy, instrOut); end
   endtask

   task automatic test_boot(input bit noise);
      on = 0; start = 1;
      tick(0, 0, 0);
      start = 0;
      n_checks++; if (busy !== 1 || romAddr !== 1) begin n_fail++; $display("FAIL boot c1: busy=%b romAddr=%h want 1 01", busy, romAddr); end
      for (int c = 2; c <= 10; c++) begin
         if (noise && c <= 9) begin
            start = 1'($urandom_range(0, 1));
            tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), AW'($urandom));
            start = 0;
         end else tick(0, 0, 0);
         if (c == 10) begin
            n_checks++; if (instrValid !== 1 || instrOut !== rom[BL] || instrOut !== exp_out || regChoose !== 0) begin n_fail++; $display("FAIL boot first fetch: instr=%h vld=%b rc=%0d want %h 1 0", instrOut, instrValid, regChoose, rom[BL]); end
         end else begin
            automatic int k = c >= 3 ? c - 2 : 0;
            n_checks++; if (regChoose !== RC'(k) || (k != 0 && regData !== rom[k])) begin n_fail++; $display("FAIL boot c%0d reg: rc=%0d rd=%h want %0d %h", c, regChoose, regData, k, rom[k]); end
            n_checks++; if (instrOut !== NOP || instrValid !== 0 || busy !== 1) begin n_fail++; $display("FAIL boot c%0d instr: instr=%h vld=%b busy=%b", c, instrOut, instrValid, busy); end
            if (c == 8) begin n_checks++; if (romAddr !== AW'(BL)) begin n_fail++; $display("FAIL boot romAddr c8: got %h want %h", romAddr, BL); end end
         end
         if (c == 9) begin on = 1; d = BL; nops = 0; exp_out = NOP; exp_vld = 0; end
      end
   endtask

   task automatic test_fetch();
      for (int i = 0; i < 12; i++) begin
         tick(0, 0, 0);
         n_checks++; if (instrOut !== W'(9 + i) || instrValid !== 1 || instrOut !== exp_out) begin n_fail++; $display("FAIL fetch seq %0d: got %h want %h", i, instrOut, 9 + i); end
      end
   endtask

   task automatic wait_word(input logic [W-1:0] w, input string nm);
      int k = 0;
      while (instrOut !== w && k < 300) begin tick(0, 0, 0); k++; end
      n_checks++; if (k == 300) begin n_fail++; $display("FAIL %s timeout: instr=%h want %h", nm, instrOut, w); end
   endtask

   task automatic test_jump();
      logic [W-1:0] ew [4];
      ew = '{NOP, NOP, 16'h0040, 16'h0041};
      wait_word(16'd20, "jump wait");
      tick(0, 1, 8'h40);
      for (int i = 0; i < 4; i++) begin
         if (i > 0) tick(0, 0, 0);
         n_checks++; if (instrOut !== ew[i] || instrValid !== (i >= 2) || instrOut !== exp_out) begin n_fail++; $display("FAIL jump %0d: got %h/%b want %h/%b", i, instrOut, instrValid, ew[i], i >= 2); end
      end
   endtask

   task automatic test_stall();
      tick(0, 1, 8'd28);
      wait_word(16'd30, "stall wait");
      for (int i = 0; i < 3; i++) begin
         tick(1, 0, 0);
         n_checks++; if (instrOut !== 16'd30 || instrValid !== 1) begin n_fail++; $display("FAIL stall hold %0d: got %h want 001e", i, instrOut); end
      end
      for (int i = 0; i < 3; i++) begin
         tick(0, 0, 0);
         n_checks++; if (instrOut !== W'(31 + i) || instrValid !== 1 || instrOut !== exp_out) begin n_fail++; $display("FAIL stall release %0d: got %h want %h", i, instrOut, 31 + i); end
      end
   endtask

   task automatic test_jump_stall();
      logic [W-1:0] ew [4];
      ew = '{NOP, NOP, 16'h3333, 16'h4444};
      tick(1, 1, 8'd3);
      for (int i = 0; i < 4; i++) begin
         if (i > 0) tick(0, 0, 0);
         n_checks++; if (instrOut !== ew[i] || instrValid !== (i >= 2)) begin n_fail++; $display("FAIL jump+stall %0d: got %h want %h", i, instrOut, ew[i]); end
      end
   endtask

   task automatic test_wrap();
      logic [W-1:0] ew [5];
      ew = '{16'h00FD, 16'h00FE, 16'h00FF, 16'h0008, 16'h0009};
      tick(0, 1, 8'hFD); tick(0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         tick(0, 0, 0);
         n_checks++; if (instrOut !== ew[i] || instrValid !== 1) begin n_fail++; $display("FAIL wrap %0d: got %h want %h", i, instrOut, ew[i]); end
      end
   endtask

   task automatic test_reset_mid_boot();
      for (int a = 0; a < 256; a++) rom[a] = W'($urandom);
      on = 0; start = 1;
      tick(0, 0, 0);
      start = 0;
      for (int i = 0; i < 4; i++) tick(0, 0, 0);
      reset = 1;
      tick(0, 0, 0);
      reset = 0;
      n_checks++; if (romAddr !== 0 || busy !== 0 || instrValid !== 0 || instrOut !== NOP || regChoose !== 0 || regData !== 0) begin n_fail++; $display("FAIL mid-boot reset: romAddr=%h busy=%b vld=%b instr=%h rc=%0d rd=%h", romAddr, busy, instrValid, instrOut, regChoose, regData); end
      tick(0, 0, 0); tick(0, 0, 0);
      n_checks++; if (romAddr !== 0 || busy !== 0) begin n_fail++; $display("FAIL post-reset idle: romAddr=%h busy=%b", romAddr, busy); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         tick(1'($urandom_range(0, 9) < 3), 1'($urandom_range(0, 19) == 0), AW'($urandom));
         n_checks++; if (instrOut !== exp_out || instrValid !== exp_vld || regChoose !== 0) begin n_fail++; $display("FAIL random %0d: instr=%h/%b rc=%0d want %h/%b 0", i, instrOut, instrValid, regChoose, exp_out, exp_vld); end
      end
   endtask

   initial begin
      fill_structured();
      test_reset();
      test_boot(0);
      test_fetch();
      test_jump();
      test_stall();
      test_jump_stall();
      test_wrap();
      test_reset_mid_boot();
      test_boot(1);
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/instruction_fetcher.md
# instruction_fetcher

Sequencer that sits between the program ROM and `InstructionProcessor`, driving its `ROMData`, `regChoose` and `regData` inputs. On `start` it runs a boot phase that loads registers 1–7 from the ROM boot block through the register-write path. It then streams instruction words from address `BOOT_LEN` upward. It supports taken-jump redirection, which squashes in-flight words, and stall, which holds the stream without losing words.

## Interface
- `WIDTH`, 16: instruction and data word width.
- `ADDR_WIDTH`, 8: ROM address width. ROM depth is 2^ADDR_WIDTH.
- `REGS_CODING`, 3: register index width.
- `BOOT_LEN`, 8: size of the boot block. Instruction fetch starts at this address.
- `NOP_WORD`, 16'h02C2: word driven on `instrOut` when no valid instruction is present (ALU op, suffix NV).

Ports:
- `clock` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `start` input 1: one-cycle pulse. Honoured only in IDLE.
- `stall` input 1: freeze the instruction stream (FETCH only).
- `jumpValid` input 1: taken branch/jump this cycle.
- `jumpTarget` input ADDR_WIDTH: redirect address.
- `romAddr` output ADDR_WIDTH: registered ROM address.
- `romData` input WIDTH: synchronous ROM q. Valid one cycle after `romAddr`.
- `instrOut` output WIDTH: to processor `ROMData`. Registered.
- `instrValid` output 1: `instrOut` holds a real instruction.
- `regChoose` output REGS_CODING: register-write index. 0 means no write.
- `regData` output WIDTH: register-write data.
- `busy` output 1: high in BOOT and FETCH.

## Operation
- States: IDLE, BOOT, FETCH.
- IDLE:
  - `romAddr`=0, `instrOut`=NOP_WORD, `instrValid`=0, `regChoose`=0, `busy`=0.
  - `start` → BOOT, with `romAddr` set to 1 on the next cycle.
- BOOT:
  - Issues addresses 1..7, one per cycle.
  - Each returned word k is presented as `regChoose`=k, `regData`=word(k), with `instrOut`=NOP_WORD and `instrValid`=0.
  - Address 0 is never loaded, because `regChoose`=0 is not a write. reg0 is not bootable.
  - After address 7 is issued, `romAddr` goes to BOOT_LEN and the state moves to FETCH.
  - `stall`, `jumpValid` and `start` are ignored in BOOT.
- FETCH:
  - `romAddr` increments by 1 each non-stalled cycle.
  - Past 2^ADDR_WIDTH−1, `romAddr` wraps to BOOT_LEN, not 0.
  - Each returned word appears on `instrOut` with `instrValid`=1 and `regChoose`=0.
  - FETCH never exits except on `reset`.
- Jump:
  - `jumpValid` at cycle n sets `romAddr`=`jumpTarget` at n+1.
  - The two words already in flight (addresses issued at n−1 and n) are squashed: `instrOut`=NOP_WORD, `instrValid`=0 at n+1 and n+2.
  - Any skid contents are discarded.
- Stall:
  - While `stall`=1, `romAddr`, `instrOut` and `instrValid` hold.
  - On the first stall cycle, `romData` (the word in flight) is captured into a one-entry skid register.
  - On release, the skid word is emitted first, then the ROM stream resumes.
  - No word is lost, duplicated or bubbled.
- Simultaneous events:
  - `jumpValid` with `stall`: the jump wins and the stall is ignored that cycle.
  - `jumpTarget` below BOOT_LEN is legal and is fetched as an instruction.
- Reset: from any state, returns to IDLE values on the next edge, and clears the skid register. A reset mid-boot leaves already-written registers as they are.

## Timing
- Reset values: `romAddr`=0, `instrOut`=NOP_WORD, `instrValid`=0, `regChoose`=0, `regData`=0, `busy`=0.
- Fetch latency: address issued at cycle t appears on `instrOut`/`regChoose` at t+2. Throughput is 1 word/cycle.
- Boot sequence, with `start` at cycle 0:
  - `busy`=1 and `romAddr`=1 at cycle 1.
  - `regChoose`=k at cycle k+2, for k=1..7 (cycles 3–9).
  - `romAddr`=BOOT_LEN at cycle 8.
  - First `instrValid`=1 at cycle 10 with word(BOOT_LEN).
- Jump: `jumpValid` at n gives the target word on `instrOut` at n+3. Penalty is 2 cycles.
- Stall:
  - `stall` high in cycles n..m−1, low at m.
  - `instrOut` is frozen at its cycle-n value through m.
  - Output at m+1 = skid word, at m+2 = word(`romAddr` frozen), then sequential.
- `regChoose` is nonzero only in BOOT. It is never nonzero in the same cycle as `instrValid`=1.

## Test plan
- Boot: ROM[1..7]=16'h1111·k, `start` at cycle 0 → `regChoose`=1..7 with `regData`=16'h1111..16'h7777 on cycles 3–9, `instrOut`=16'h02C2 throughout, first `instrValid` at cycle 10 with ROM[8].
- Sequential fetch: ROM[a]=a → `instrOut`=8,9,10,… on consecutive cycles. At ADDR_WIDTH=4, after 15 the next word is 8.
- Jump: `jumpValid` with target 16'h40 while fetching 20 → two NOP_WORD with `instrValid`=0, then 0x40, 0x41.
- Stall: 3-cycle stall mid-stream at words 30/31 → `instrOut` holds 30 for 4 cycles, then 31, 32, 33 with no gaps or repeats.
- Jump during stall, and stall/jump/start during BOOT → the jump redirects with 2 NOPs; the BOOT sequence is unchanged.
- Reset asserted at cycle 5 of BOOT → next cycle all outputs at reset values, state IDLE. A new `start` reruns the full boot.
